regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the pipeline's integer register file.
- Generalised in data width, register count and number of read ports.
- Adds three things:
  - same-cycle write-to-read bypass;
  - a per-register busy scoreboard for the decode/issue stage;
  - a post-reset sequencer that sweeps every register to zero.
- Sits between decode (read/reserve) and writeback (write).

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of registers; power of two, at least 2. AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- ZERO_REG, 1, when 1 register 0 reads as 0, is never written and is never busy.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- ready  out  1  high once the init sweep is complete.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback register index.
- wr_data  in  XLEN  writeback data.
- rsv_en  in  1  reserve the destination register of the instruction being issued.
- rsv_addr  in  AW  register index to mark busy.
- rd_addr  in  NRD*AW  packed read indices; port p is at [p*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational.
- rd_busy  out  NRD  per-port busy flag, combinational.

Behaviour:
- Reset (sampled at posedge while reset==0):
  - state <= INIT, clr_idx <= 0, all busy bits <= 0.
  - Register contents are not cleared directly; the INIT sweep clears them.
  - Outputs while reset==0: ready=0, rd_data=0, rd_busy=0.
- FSM states are INIT and RUN.
- INIT:
  - Each cycle writes Registers[clr_idx] <= 0, then clr_idx increments.
  - When clr_idx==NREGS-1 is written, next state is RUN.
  - The sweep takes exactly NREGS cycles after reset deasserts.
  - ready=0, rd_data=0, rd_busy=0.
  - wr_en and rsv_en are ignored and have no effect.
- RUN:
  - ready=1. RUN persists until reset is asserted.
  - Reset asserted mid-operation returns the block to INIT, restarts the sweep from index 0 and clears the scoreboard.
- Write:
  - In RUN, if wr_en and !(ZERO_REG && wr_addr==0), then Registers[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Reserve:
  - In RUN, if rsv_en and !(ZERO_REG && rsv_addr==0), then busy[rsv_addr] <= 1.
  - Reserve and write to the same address in the same cycle: the busy bit ends 1 (the new reservation wins); data is still written.
  - Reserve and write to different addresses in the same cycle: both take effect.
- Read port p (RUN, combinational, evaluated in this order):
  - ZERO_REG && addr==0: data 0, busy 0.
  - Otherwise, wr_en && wr_addr==addr: data wr_data (bypass), busy 0.
  - Otherwise: data Registers[addr], busy busy[addr].
- Read ports are independent; all NRD ports may address the same register.
- Read latency is 0 cycles. Write-to-read latency is 0 cycles via bypass. Reserve-to-busy latency is 1 cycle.
- No X may propagate on any output after the first posedge with reset==0.

Test Plan:
- Init sweep: hold reset=0 for 2 cycles, then release.
  - ready stays 0 for exactly 32 cycles, then rises.
  - All 32 registers read 0x0 on both ports.
  - wr_en=1, wr_addr=5, wr_data=0xAA applied during INIT leaves reg5=0 afterwards.
- Write/read: in RUN, write reg7=0xDEAD_BEEF_0123_4567.
  - Next cycle, rd_addr port0=7 returns the value.
  - Writing reg0=0xFF still reads 0 with ZERO_REG=1.
- Bypass: wr_en=1, wr_addr=3, wr_data=0x55 with rd_addr port1=3 in the same cycle.
  - rd_data port1=0x55 in that cycle; rd_busy[1]=0 even if reg3 is reserved.
- Scoreboard:
  - rsv_en on reg9: next cycle rd_busy=1 on a port reading 9.
  - Write reg9: busy clears from the following cycle.
  - Simultaneous rsv_en and wr_en to reg9: busy stays 1 and the data is updated.
- Mid-operation reset: reserve reg4, write reg4=0x77, then pulse reset=0 for 1 cycle.
  - ready drops, busy clears, and after 32 cycles reg4 reads 0.
- Parameter sweep: XLEN=32, NREGS=16, NRD=3, ZERO_REG=0.
  - Init takes 16 cycles; reg0 is writable and reservable.
  - Three ports reading the same register return identical data.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with write-to-read bypass, per-register busy
// scoreboard for issue, and a post-reset sweep that zeroes every register.
module regfile_scoreboard #(
    parameter  int unsigned XLEN     = 64,
    parameter  int unsigned NREGS    = 32,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy
);

    localparam bit ZR = (ZERO_REG != 0);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic              run_c;
    logic              wr_ok_c;
    logic              rsv_ok_c;
    logic [AW-1:0]     rd_idx;

    // Reset holds outputs quiet in the same cycle it is asserted, even though it acts on the next edge.
    assign run_c    = (state_q == ST_RUN) && reset;
    assign ready    = run_c;
    assign wr_ok_c  = wr_en  && !(ZR && (wr_addr  == '0));
    assign rsv_ok_c = rsv_en && !(ZR && (rsv_addr == '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    // Next state, sweep write port and scoreboard update; a same-cycle reservation beats the clearing write.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_ok_c) begin
                    mem_we          = 1'b1;
                    mem_waddr       = wr_addr;
                    mem_wdata       = wr_data;
                    busy_d[wr_addr] = 1'b0;
                end
                if (rsv_ok_c) begin
                    busy_d[rsv_addr] = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Read ports: hardwired zero register, then writeback bypass, then array and scoreboard.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_idx  = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            rd_idx = rd_addr[p*AW +: AW];
            if (run_c && !(ZR && (rd_idx == '0))) begin
                if (wr_en && (wr_addr == rd_idx)) begin
                    rd_data[p*XLEN +: XLEN] = wr_data;
                end else begin
                    rd_data[p*XLEN +: XLEN] = regs_q[rd_idx];
                    rd_busy[p]              = busy_q[rd_idx];
                end
            end
        end
    end

endmodule
